mc_control_fsm: RTL and testbench

- Moore-style multicycle control unit for the 32-bit MIPS-subset datapath.
- Sequences every datapath select and write-enable: ALUSrcA/ALUSrcB muxes, ALU operation, PC source, IorD, register-file and memory writes.
- Sits beside the datapath; takes the opcode/funct fields of the latched instruction, plus the ALU zero and overflow flags.

---
 rtl/mc_control_fsm.sv | 196 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control FSM: Moore decode of all datapath selects and write enables.
// Define OVERFLOW_EXC_EN to route signed add/sub/addi overflow to the EXC state (EPC load + vector).
module mc_control_fsm #(
  parameter int EXC_STATE_EN_DUMMY = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcBControl,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSource,
  output logic       EPCWrite,
  output logic       illegal_op,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_R_EXEC     = 4'd4,
    S_R_WB       = 4'd5,
    S_I_EXEC     = 4'd6,
    S_I_WB       = 4'd7,
    S_MEM_ADDR   = 4'd8,
    S_LW_READ    = 4'd9,
    S_LW_WAIT    = 4'd10,
    S_LW_WB      = 4'd11,
    S_SW_WRITE   = 4'd12,
    S_BRANCH     = 4'd13,
    S_JUMP       = 4'd14,
    S_EXC        = 4'd15
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     state, state_next;
  logic [2:0] r_alu_op;
  logic       unused_ok;

  // overflow only matters with the exception feature; the parameter is reserved.
  assign unused_ok = overflow ^ (EXC_STATE_EN_DUMMY != 0);
  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    r_alu_op = ALU_ADD;
    case (funct)
      6'h20:   r_alu_op = ALU_ADD;
      6'h22:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h2A:   r_alu_op = ALU_SLT;
      default: r_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next     = S_FETCH;
    PCWrite        = 1'b0;
    IorD           = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    ABWrite        = 1'b0;
    ALUOutWrite    = 1'b0;
    RegDst         = 1'b0;
    MemtoReg       = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcBControl = 2'b00;
    ALUControl     = 3'b000;
    PCSource       = 2'b00;
    EPCWrite       = 1'b0;
    illegal_op     = 1'b0;
    case (state)
      S_FETCH: begin
        IorD       = 1'b0;
        state_next = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        IRWrite        = 1'b1;
        ALUSrcBControl = 2'b01;
        ALUControl     = ALU_ADD;
        PCWrite        = 1'b1;
        state_next     = S_DECODE;
      end
      S_DECODE: begin
        // Branch target PC + (imm<<2) is precomputed here into ALUOut.
        ALUSrcBControl = 2'b11;
        ALUControl     = ALU_ADD;
        ALUOutWrite    = 1'b1;
        ABWrite        = 1'b1;
        case (opcode)
          6'h00:        state_next = S_R_EXEC;
          6'h08:        state_next = S_I_EXEC;
          6'h23, 6'h2B: state_next = S_MEM_ADDR;
          6'h04:        state_next = S_BRANCH;
          6'h02:        state_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        ALUSrcA        = 1'b1;
        ALUSrcBControl = 2'b10;
        ALUControl     = r_alu_op;
        ALUOutWrite    = 1'b1;
        state_next     = S_R_WB;
`ifdef OVERFLOW_EXC_EN
        if (overflow && (funct == 6'h20 || funct == 6'h22)) state_next = S_EXC;
`endif
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUControl  = ALU_ADD;
        ALUOutWrite = 1'b1;
        state_next  = S_I_WB;
`ifdef OVERFLOW_EXC_EN
        if (overflow) state_next = S_EXC;
`endif
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUControl  = ALU_ADD;
        ALUOutWrite = 1'b1;
        state_next  = (opcode == 6'h23) ? S_LW_READ : S_SW_WRITE;
      end
      S_LW_READ: begin
        IorD       = 1'b1;
        state_next = S_LW_WAIT;
      end
      S_LW_WAIT: begin
        IorD       = 1'b1;
        state_next = S_LW_WB;
      end
      S_LW_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_SW_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA        = 1'b1;
        ALUSrcBControl = 2'b10;
        ALUControl     = ALU_SUB;
        PCSource       = 2'b01;
        PCWrite        = zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
`ifdef OVERFLOW_EXC_EN
      S_EXC: begin
        EPCWrite = 1'b1;
        PCSource = 2'b11;
        PCWrite  = 1'b1;
      end
`endif
      // RESET, and EXC when the feature is off: everything idle, go fetch.
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expected observations come from an instruction-level model.
// Build with OVERFLOW_EXC_EN defined to exercise the overflow exception path.
module tb_mc_control_fsm;

  localparam int W = 23;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iord, memw, irw, abw, aluow, regdst, memtoreg, regw, srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       epcw, ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       PCWrite, IorD, MemWrite, IRWrite, ABWrite, ALUOutWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, EPCWrite, illegal_op;
  logic [1:0] ALUSrcBControl, PCSource;
  logic [2:0] ALUControl;
  logic [3:0] state_out;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int obs_n = 0;
  logic mon_en = 1'b0;

  mc_control_fsm #(.EXC_STATE_EN_DUMMY(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .ABWrite(ABWrite),
    .ALUOutWrite(ALUOutWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcBControl(ALUSrcBControl), .ALUControl(ALUControl),
    .PCSource(PCSource), .EPCWrite(EPCWrite), .illegal_op(illegal_op), .state_out(state_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // reference model: what the datapath controls must be in a given step of an instruction
  function automatic obs_t step_obs(int st, logic [5:0] op, logic [5:0] fn, logic z);
    obs_t o;
    o = '0;
    o.st = st[3:0];
    case (st)
      2: begin o.irw = 1; o.srcb = 2'b01; o.aluc = 3'b001; o.pcw = 1; end
      3: begin
        o.srcb = 2'b11; o.aluc = 3'b001; o.aluow = 1; o.abw = 1;
        o.ill = !(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
      end
      4: begin
        o.srca = 1; o.srcb = 2'b10; o.aluow = 1;
        o.aluc = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : (fn == 6'h2A) ? 3'b111 : 3'b001;
      end
      5: begin o.regdst = 1; o.regw = 1; end
      6, 8: begin o.srca = 1; o.aluc = 3'b001; o.aluow = 1; end
      7: o.regw = 1;
      9, 10: o.iord = 1;
      11: begin o.memtoreg = 1; o.regw = 1; end
      12: begin o.iord = 1; o.memw = 1; end
      13: begin o.srca = 1; o.srcb = 2'b10; o.aluc = 3'b010; o.pcsrc = 2'b01; o.pcw = z; end
      14: begin o.pcsrc = 2'b10; o.pcw = 1; end
      15: begin o.epcw = 1; o.pcsrc = 2'b11; o.pcw = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // path of states an instruction walks through, starting at fetch
  function automatic void instr_path(logic [5:0] op, logic [5:0] fn, logic ov, output int p[$]);
    logic exc;
    exc = 1'b0;
`ifdef OVERFLOW_EXC_EN
    exc = ov && ((op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08);
`else
    exc = ov & 1'b0;
`endif
    p = '{1, 2, 3};
    case (op)
      6'h00: begin p.push_back(4); p.push_back(exc ? 15 : 5); end
      6'h08: begin p.push_back(6); p.push_back(exc ? 15 : 7); end
      6'h23: begin p.push_back(8); p.push_back(9); p.push_back(10); p.push_back(11); end
      6'h2B: begin p.push_back(8); p.push_back(12); end
      6'h04: p.push_back(13);
      6'h02: p.push_back(14);
      default: ;
    endcase
  endfunction

  // driver: hold the instruction fields for the whole instruction, queue expectations
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    int p[$];
    instr_path(op, fn, ov, p);
    opcode = op; funct = fn; zero = z; overflow = ov;
    foreach (p[i]) exp_q.push_back(step_obs(p[i], op, fn, z));
    repeat (p.size()) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] got, exp;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = {state_out, PCWrite, IorD, MemWrite, IRWrite, ABWrite, ALUOutWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcBControl, ALUControl, PCSource, EPCWrite,
               illegal_op};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL obs[%0d] unexpected output got=%h exp=<none>", obs_n, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL obs[%0d] got=%h exp=%h (state got=%0d exp=%0d)",
                     obs_n, got, exp, got[22:19], exp[22:19]);
          end
        end
        obs_n++;
      end
    end
  end

  function automatic logic [5:0] rand_illegal();
    logic [5:0] v;
    do v = 6'($urandom_range(0, 63));
    while (v inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
    return v;
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [5:0] tbl [5];
    tbl = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h00};
    tbl[4] = 6'($urandom_range(0, 63));
    return tbl[$urandom_range(0, 4)];
  endfunction

  initial begin
    int p[$];
    logic [5:0] ops [6];
    obs_t z0;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    z0 = '0;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(z0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // directed instructions
    issue(6'h08, 6'h00, 1'b0, 1'b0);
    issue(6'h00, 6'h20, 1'b0, 1'b0);
    issue(6'h00, 6'h22, 1'b1, 1'b0);
    issue(6'h00, 6'h24, 1'b0, 1'b0);
    issue(6'h00, 6'h2A, 1'b0, 1'b0);
    issue(6'h00, 6'h3F, 1'b0, 1'b0);
    issue(6'h23, 6'h00, 1'b0, 1'b0);
    issue(6'h2B, 6'h00, 1'b0, 1'b0);
    issue(6'h04, 6'h00, 1'b1, 1'b0);
    issue(6'h04, 6'h00, 1'b0, 1'b0);
    issue(6'h02, 6'h00, 1'b0, 1'b0);
    issue(6'h3F, 6'h00, 1'b0, 1'b0);
    issue(6'h00, 6'h20, 1'b0, 1'b1);
    issue(6'h00, 6'h22, 1'b0, 1'b1);
    issue(6'h00, 6'h24, 1'b0, 1'b1);
    issue(6'h08, 6'h00, 1'b0, 1'b1);

    // reset mid-instruction, during the lw memory wait
    instr_path(6'h23, 6'h00, 1'b0, p);
    opcode = 6'h23; funct = 6'h00; zero = 1'b0; overflow = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(step_obs(p[i], 6'h23, 6'h00, 1'b0));
    exp_q.push_back(z0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = rand_illegal();
      else op = ops[$urandom_range(0, 5)];
      issue(op, rand_funct(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
